dunit_loader: RTL and testbench
===============================

# dunit_loader

Debug-unit front end that drives the instruction-fetch stage's debug inputs. It assembles a serial byte stream (from the UART receiver) into 32-bit instruction words and writes them into instruction memory over the debug write port. It then gates the pipeline clock enable for continuous run or single-step execution. It sits directly upstream of IF and owns `o_dunit_w_en`, `o_dunit_addr`, `o_dunit_data` and `o_dunit_clk_en`.

## Interface

Parameters:
- `NB_REG`, 32, instruction/data word width
- `NB_WIDHT`, 9, instruction memory byte-address width (512 bytes, 128 words)
- `NB_BYTE`, 8, serial byte width
- `HALT_WORD`, 32'hFFFF_FFFF, encoding that terminates a load

Ports:
- `i_clk` in 1: single clock, all logic on rising edge
- `i_reset` in 1: asynchronous, active-low reset
- `i_load_req` in 1: one-cycle pulse, start (re)loading program
- `i_rx_data` in `NB_BYTE`: received byte
- `i_rx_valid` in 1: one-cycle strobe, `i_rx_data` valid
- `i_run_req` in 1: pulse, start continuous execution
- `i_step_req` in 1: pulse, execute one pipeline cycle
- `i_halt` in 1: HALT instruction retired by the pipeline
- `o_dunit_clk_en` out 1: pipeline/PC clock enable
- `o_dunit_w_en` out 1: instruction memory write enable
- `o_dunit_addr` out `NB_WIDHT`: byte address of the word being written, word aligned
- `o_dunit_data` out `NB_REG`: word being written
- `o_load_busy` out 1: high in LOAD/WRITE
- `o_load_done` out 1: program loaded, sticky until next `i_load_req`
- `o_overflow` out 1: memory filled without HALT_WORD
- `o_word_count` out `NB_WIDHT-1`: words written in current load (0..128)
- `o_state` out 3: state encoding for debug readout

## Operation

States: IDLE, LOAD, WRITE, READY, RUN, STEP, DONE.
- **Decoded outputs (Moore):**
  - `o_dunit_clk_en` = (RUN | STEP).
  - `o_dunit_w_en` = WRITE.
  - `o_load_busy` = (LOAD | WRITE).
- **IDLE:** waits. `i_load_req` → LOAD. On this transition: `o_dunit_addr`=0, byte counter=0, `o_word_count`=0, `o_load_done`=0, `o_overflow`=0.
- **LOAD:** each `i_rx_valid` shifts a byte into the assembly register, first byte → bits [31:24] (big-endian). The 4th accepted byte causes the transition → WRITE, with the complete word copied into the `o_dunit_data` register.
- **WRITE:** one cycle with `w_en`=1. `o_word_count`++. Next state is chosen as follows:
  - Word == HALT_WORD → READY, `o_load_done`=1.
  - Else if address == 4*(2^(NB_WIDHT-2)-1) (508) → READY, `o_load_done`=1, `o_overflow`=1.
  - Else → LOAD with address += 4.
- **Byte during WRITE:** an `i_rx_valid` in WRITE is accepted as byte 0 of the next word, because the assembly register is independent of the data register. It is discarded if the next state is READY.
- **READY:** priority order is `i_load_req` (→ LOAD, same init as from IDLE) > `i_run_req` (→ RUN) > `i_step_req` (→ STEP).
- **RUN:** clock enabled every cycle. `i_halt` → DONE. `i_load_req` ignored.
- **STEP:** exactly one cycle with enable. Next state is DONE if `i_halt` is high in that cycle, else READY.
- **DONE:** clock enable off. `i_run_req`/`i_step_req` ignored. `i_load_req` → LOAD.
- **`i_load_req` in LOAD/WRITE:** restarts the load (same init), discarding the partial word.
- **Address arithmetic:** `o_dunit_addr`[1:0] always 0. The address never wraps; overflow ends the load instead.

## Timing

- **Reset (async assert):** state=IDLE and every output 0 (`o_state`=IDLE code). No memory writes during or after reset. Memory contents are not cleared.
- **Byte-to-write latency:** 4th `i_rx_valid` at cycle N → `w_en` high in cycle N+1 with addr/data stable for that whole cycle.
- **Back-to-back bytes:** every-cycle `i_rx_valid` is sustainable without loss.
- **Run start:** `i_run_req` at cycle N → `clk_en` high from N+1.
- **Halt:** `i_halt` high at cycle M in RUN → `clk_en` high in M, low from M+1.
- **Step:** `i_step_req` at cycle N → `clk_en` high in N+1 only.
- **Simultaneous `i_rx_valid` and `i_load_req` in LOAD:** the restart wins and the byte is dropped.

## Structure

- Shared package `dunit_pkg`: state encodings (3-bit), HALT_WORD default, byte-per-word constant (4).
- One natural sub-module: `word_assembler` (byte counter + shift register, emits word + `word_valid`). The FSM, address/count counters and output decode stay in the top.

## Test plan

- **Reset then load:** reset low mid-LOAD after 2 bytes, release, send 0x20,0x01,0x00,0x05 then FF×4 → writes 0x20010005 @0 and 0xFFFFFFFF @4; `o_word_count`=2; `o_load_done`=1; state READY.
- **Byte order/back-to-back:** 8 consecutive-cycle bytes 0x11..0x88 → words 0x11223344 @0, 0x55667788 @4, each `w_en` exactly one cycle.
- **Overflow:** 128 non-halt words → last write @508; `o_overflow`=1; `o_load_done`=1; `o_word_count`=128; no write beyond 508.
- **Run/halt:** READY, `i_run_req` at N, `i_halt` at N+10 → `clk_en` high N+1..N+10, state DONE, later run/step pulses ignored.
- **Step:** three `i_step_req` pulses 5 cycles apart → three single-cycle `clk_en` pulses; then step with `i_halt` → DONE.
- **Priority/restart:** in READY, `i_load_req` with `i_run_req` → LOAD. During LOAD, `i_load_req` after 3 bytes → addr back to 0, partial word never written.

Source files
------------

// File: rtl/dunit_pkg.sv
// Shared definitions for the debug-unit loader: FSM state codes and word constants.
package dunit_pkg;

  localparam int              BYTES_PER_WORD = 4;
  localparam logic [31:0]     HALT_WORD_DEF  = 32'hFFFF_FFFF;

  // 3-bit codes, also exported on o_state for debug readout
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_READY = 3'd3,
    S_RUN   = 3'd4,
    S_STEP  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/dunit_loader_if.sv
// Byte stream in from the UART receiver, debug write port out to instruction memory.
interface dunit_loader_if #(
  parameter int NB_REG   = 32,
  parameter int NB_WIDHT = 9,
  parameter int NB_BYTE  = 8
);
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                o_dunit_w_en;
  logic [NB_WIDHT-1:0] o_dunit_addr;
  logic [NB_REG-1:0]   o_dunit_data;

  modport master (input i_rx_data, i_rx_valid,
                  output o_dunit_w_en, o_dunit_addr, o_dunit_data);
  modport slave  (output i_rx_data, i_rx_valid,
                  input o_dunit_w_en, o_dunit_addr, o_dunit_data);
endinterface

// File: rtl/dunit_loader_word_assembler.sv
// Big-endian byte-to-word packer. The word is presented combinationally together
// with the last byte so the caller can latch it in the same cycle.
module word_assembler #(
  parameter int NB_BYTE = 8,
  parameter int N_BYTES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_byte_valid,
  input  logic [NB_BYTE-1:0]         i_byte,
  output logic [NB_BYTE*N_BYTES-1:0] o_word,
  output logic                       o_word_valid
);
  localparam int                NB_CNT = $clog2(N_BYTES);
  localparam logic [NB_CNT-1:0] LAST   = NB_CNT'(N_BYTES - 1);

  logic [NB_CNT-1:0]                cnt;
  logic [NB_BYTE*(N_BYTES-1)-1:0]   shreg;

  assign o_word       = {shreg, i_byte};
  assign o_word_valid = i_byte_valid && !i_clear && (cnt == LAST);

  // shift accepted bytes in at the bottom; clear drops any partial word
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (i_clear) begin
      cnt   <= '0;
    end else if (i_byte_valid) begin
      shreg <= o_word[NB_BYTE*(N_BYTES-1)-1:0];
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dunit_loader.sv
// Debug-unit front end: loads a program from the serial byte stream into
// instruction memory, then gates the pipeline clock for run / single-step.
module dunit_loader
  import dunit_pkg::*;
#(
  parameter int                NB_REG    = 32,
  parameter int                NB_WIDHT  = 9,
  parameter int                NB_BYTE   = 8,
  parameter logic [NB_REG-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load_req,
  input  logic                i_run_req,
  input  logic                i_step_req,
  input  logic                i_halt,
  dunit_loader_if.master      bus,
  output logic                o_dunit_clk_en,
  output logic                o_load_busy,
  output logic                o_load_done,
  output logic                o_overflow,
  output logic [NB_WIDHT-2:0] o_word_count,
  output logic [2:0]          o_state
);
  // last word-aligned address; reaching it without a halt word ends the load
  localparam logic [NB_WIDHT-1:0] LAST_ADDR =
    NB_WIDHT'(BYTES_PER_WORD * ((1 << (NB_WIDHT - 2)) - 1));
  localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(BYTES_PER_WORD);

  state_e              state, state_n;
  logic                init;
  logic                byte_accept, word_valid;
  logic [NB_REG-1:0]   word;
  logic [NB_WIDHT-1:0] addr_q;
  logic [NB_REG-1:0]   data_q;
  logic [NB_WIDHT-2:0] wcnt_q;
  logic                done_q, ovf_q;
  logic                is_halt, at_last;

  assign is_halt = (data_q == HALT_WORD);
  assign at_last = (addr_q == LAST_ADDR);

  // A byte in WRITE starts the next word only if the load continues; a
  // simultaneous load request restarts and drops the byte.
  assign byte_accept = bus.i_rx_valid && !i_load_req &&
                       ((state == S_LOAD) ||
                        ((state == S_WRITE) && !is_halt && !at_last));

  word_assembler #(.NB_BYTE(NB_BYTE), .N_BYTES(BYTES_PER_WORD)) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (init),
    .i_byte_valid (byte_accept),
    .i_byte       (bus.i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_n;
  end

  // next-state logic and load-init strobe
  always_comb begin
    state_n = state;
    init    = 1'b0;
    unique case (state)
      S_IDLE: if (i_load_req) begin
        state_n = S_LOAD;
        init    = 1'b1;
      end
      S_LOAD: begin
        if (i_load_req) begin
          state_n = S_LOAD;
          init    = 1'b1;
        end else if (word_valid) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_load_req) begin
          state_n = S_LOAD;
          init    = 1'b1;
        end else if (is_halt || at_last) begin
          state_n = S_READY;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_READY: begin
        if (i_load_req) begin
          state_n = S_LOAD;
          init    = 1'b1;
        end else if (i_run_req) begin
          state_n = S_RUN;
        end else if (i_step_req) begin
          state_n = S_STEP;
        end
      end
      S_RUN:  if (i_halt) state_n = S_DONE;
      S_STEP: state_n = i_halt ? S_DONE : S_READY;
      S_DONE: if (i_load_req) begin
        state_n = S_LOAD;
        init    = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // address, word count, status flags and the write-data register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q <= '0;
      data_q <= '0;
      wcnt_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (init) begin
      addr_q <= '0;
      wcnt_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == S_LOAD) begin
      if (word_valid) data_q <= word;
    end else if (state == S_WRITE) begin
      wcnt_q <= wcnt_q + 1'b1;
      if (is_halt) begin
        done_q <= 1'b1;
      end else if (at_last) begin
        done_q <= 1'b1;
        ovf_q  <= 1'b1;
      end else begin
        addr_q <= addr_q + ADDR_STEP;
      end
    end
  end

  // Moore output decode
  assign o_dunit_clk_en   = (state == S_RUN) || (state == S_STEP);
  assign bus.o_dunit_w_en = (state == S_WRITE);
  assign o_load_busy      = (state == S_LOAD) || (state == S_WRITE);
  assign bus.o_dunit_addr = addr_q;
  assign bus.o_dunit_data = data_q;
  assign o_load_done      = done_q;
  assign o_overflow       = ovf_q;
  assign o_word_count     = wcnt_q;
  assign o_state          = state;

endmodule

// File: tb/tb_dunit_loader.sv
// Bench for dunit_loader: scoreboarded memory writes plus a vector table for run/halt.
module tb_dunit_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0, run_req = 1'b0, step_req = 1'b0, halt = 1'b0;
  logic       clk_en, busy, done, ovf;
  logic [7:0] wcnt;
  logic [2:0] st;

  int n_checks = 0;
  int n_fail   = 0;

  dunit_loader_if bus ();

  dunit_loader dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_load_req     (load_req),
    .i_run_req      (run_req),
    .i_step_req     (step_req),
    .i_halt         (halt),
    .bus            (bus),
    .o_dunit_clk_en (clk_en),
    .o_load_busy    (busy),
    .o_load_done    (done),
    .o_overflow     (ovf),
    .o_word_count   (wcnt),
    .o_state        (st)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic       ld, run, step, hlt;
    logic       exp_en;
    logic [2:0] exp_st;
  } vec_t;
  vec_t tbl[14];

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_READY = 3'd3,
                         ST_RUN = 3'd4, ST_STEP = 3'd5, ST_DONE = 3'd6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  // queue the expected write, then stream the word MSB first
  task automatic send_word(input logic [8:0] a, input logic [31:0] w);
    sb.push_back({a, w});
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // every memory write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.o_dunit_w_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", {23'd0, bus.o_dunit_addr}, 32'h1FF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", {23'd0, bus.o_dunit_addr}, {23'd0, e.addr});
        check("write_data", bus.o_dunit_data, e.data);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // run/halt table: rows are inputs for one cycle and the result after that edge
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ST_RUN};
    for (int i = 1; i <= 9; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_RUN};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ST_RUN};   // load ignored while running
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_DONE};  // halt
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_DONE};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST_DONE};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ST_DONE};

    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_state", {29'd0, st}, {29'd0, ST_IDLE});
    check("rst_outs", {25'd0, clk_en, bus.o_dunit_w_en, busy, done, ovf, 2'b00}, 32'd0);
    check("rst_addr", {23'd0, bus.o_dunit_addr}, 32'd0);
    check("rst_data", bus.o_dunit_data, 32'd0);
    check("rst_wcnt", {24'd0, wcnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // async reset in the middle of a load
    pulse_load();
    check("load_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_state", {29'd0, st}, {29'd0, ST_IDLE});
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // clean load: one word then the halt word
    pulse_load();
    send_word(9'd0, 32'h2001_0005);
    send_word(9'd4, 32'hFFFF_FFFF);
    tick();
    check("load1_state", {29'd0, st}, {29'd0, ST_READY});
    check("load1_wcnt", {24'd0, wcnt}, 32'd2);
    check("load1_done", {31'd0, done}, 32'd1);
    check("load1_ovf", {31'd0, ovf}, 32'd0);

    // load beats run in READY, then back-to-back bytes (5th lands in WRITE)
    load_req = 1'b1;
    run_req  = 1'b1;
    tick();
    load_req = 1'b0;
    run_req  = 1'b0;
    check("prio_state", {29'd0, st}, {29'd0, ST_LOAD});
    check("prio_clk_en", {31'd0, clk_en}, 32'd0);
    check("prio_done_clr", {31'd0, done}, 32'd0);
    send_word(9'd0, 32'h1122_3344);
    send_word(9'd4, 32'h5566_7788);

    // partial word then restart together with a byte: both discarded
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    check("pre_restart_addr", {23'd0, bus.o_dunit_addr}, 32'd8);
    load_req       = 1'b1;
    bus.i_rx_data  = 8'hAA;
    bus.i_rx_valid = 1'b1;
    tick();
    load_req       = 1'b0;
    bus.i_rx_valid = 1'b0;
    check("restart_addr", {23'd0, bus.o_dunit_addr}, 32'd0);
    check("restart_wcnt", {24'd0, wcnt}, 32'd0);
    send_word(9'd0, 32'hFFFF_FFFF);
    tick();
    check("restart_state", {29'd0, st}, {29'd0, ST_READY});
    check("restart_wcnt_end", {24'd0, wcnt}, 32'd1);

    // run / halt / ignored requests from the vector table
    for (int i = 0; i < 14; i++) begin
      load_req = tbl[i].ld;
      run_req  = tbl[i].run;
      step_req = tbl[i].step;
      halt     = tbl[i].hlt;
      tick();
      {load_req, run_req, step_req, halt} = 4'b0000;
      check($sformatf("tbl%0d_clk_en", i), {31'd0, clk_en}, {31'd0, tbl[i].exp_en});
      check($sformatf("tbl%0d_state", i), {29'd0, st}, {29'd0, tbl[i].exp_st});
    end

    // reload from DONE, then single steps
    pulse_load();
    send_word(9'd0, 32'hFFFF_FFFF);
    tick();
    check("reload_state", {29'd0, st}, {29'd0, ST_READY});
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      check($sformatf("step%0d_on", p), {31'd0, clk_en}, 32'd1);
      check($sformatf("step%0d_st", p), {29'd0, st}, {29'd0, ST_STEP});
      tick();
      check($sformatf("step%0d_off", p), {31'd0, clk_en}, 32'd0);
      check($sformatf("step%0d_ready", p), {29'd0, st}, {29'd0, ST_READY});
      repeat (3) tick();
      check($sformatf("step%0d_quiet", p), {31'd0, clk_en}, 32'd0);
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    halt     = 1'b1;
    tick();
    halt     = 1'b0;
    check("step_halt_state", {29'd0, st}, {29'd0, ST_DONE});
    check("step_halt_en", {31'd0, clk_en}, 32'd0);

    // overflow: 128 non-halt words fill memory
    pulse_load();
    for (int i = 0; i < 128; i++)
      send_word(9'(i * 4), {8'(i), 8'hA5, 8'h3C, 8'(i) ^ 8'h0F});
    tick();
    check("ovf_state", {29'd0, st}, {29'd0, ST_READY});
    check("ovf_flag", {31'd0, ovf}, 32'd1);
    check("ovf_done", {31'd0, done}, 32'd1);
    check("ovf_wcnt", {24'd0, wcnt}, 32'd128);
    check("ovf_addr", {23'd0, bus.o_dunit_addr}, 32'd508);
    // bytes in READY must not produce writes
    for (int k = 0; k < 4; k++) send_byte(8'h77);
    repeat (2) tick();
    check("ready_ignores_bytes", {29'd0, st}, {29'd0, ST_READY});
    check("sb_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
